// File: rtl/spi_master_arbiter.sv
// rtl/spi_master_arbiter.sv - two-requester round-robin SPI master, 8-bit LSB-first full-duplex frames
module spi_master_arbiter #(
   parameter int CLK_DIV = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic [7:0] wdata0,
   input  logic [7:0] wdata1,
   output logic [7:0] rdata,
   output logic [1:0] done,
   output logic       gnt_id,
   output logic       busy,
   output logic       scl,
   output logic       cs,
   output logic       mosi,
   input  logic       miso
);
   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [PW-1:0] phase;
   logic          phase_end;
   logic          grant;
   logic          winner;
   logic          last_gnt;
   logic [7:0]    tx;
   logic [7:0]    rx;
   logic [2:0]    bit_idx;

   assign phase_end = (phase == PW'(CLK_DIV - 1));
   // The last GAP cycle is also a grant slot, giving an 18 half-period frame cadence
   assign grant  = (|req) && ((state == IDLE) || ((state == GAP) && phase_end));
   assign winner = (req == 2'b11) ? ~last_gnt : req[1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         phase    <= '0;
         tx       <= '0;
         rx       <= '0;
         bit_idx  <= '0;
         mosi     <= 1'b0;
         rdata    <= '0;
         done     <= '0;
         gnt_id   <= 1'b0;
         last_gnt <= 1'b1;
      end else begin
         state <= state_nxt;
         done  <= '0;
         if ((state == IDLE) || phase_end) begin
            phase <= '0;
         end else begin
            phase <= phase + PW'(1);
         end
         if (grant) begin
            tx      <= winner ? wdata1 : wdata0;
            mosi    <= winner ? wdata1[0] : wdata0[0];
            gnt_id  <= winner;
            bit_idx <= '0;
         end
         if ((state == HIGH) && phase_end) begin
            rx[bit_idx] <= miso;
            if (bit_idx != 3'd7) begin
               bit_idx <= bit_idx + 3'd1;
               mosi    <= tx[bit_idx + 3'd1];
            end
         end
         if ((state == HOLD) && phase_end) begin
            rdata        <= rx;
            done[gnt_id] <= 1'b1;
            last_gnt     <= gnt_id;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (|req) state_nxt = SETUP;
         SETUP:   if (phase_end) state_nxt = HIGH;
         HIGH:    if (phase_end) state_nxt = (bit_idx == 3'd7) ? HOLD : LOW;
         LOW:     if (phase_end) state_nxt = HIGH;
         HOLD:    if (phase_end) state_nxt = GAP;
         GAP:     if (phase_end) state_nxt = (|req) ? SETUP : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cs   = 1'b1;
      scl  = 1'b0;
      busy = 1'b1;
      case (state)
         IDLE:              busy = 1'b0;
         SETUP, LOW, HOLD:  cs = 1'b0;
         HIGH: begin
            cs  = 1'b0;
            scl = 1'b1;
         end
         GAP:               busy = 1'b1;
         default:           busy = 1'b0;
      endcase
   end
endmodule

// File: tb/tb_spi_master_arbiter.sv
// tb/tb_spi_master_arbiter.sv - self-checking bench for spi_master_arbiter at CLK_DIV 2 and 1
module tb_spi_master_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [1:0] req_a = '0, req_b = '0;
   logic [7:0] w0_a = '0, w1_a = '0, w0_b = '0, w1_b = '0;
   logic [7:0] rdata_a, rdata_b;
   logic [1:0] done_a, done_b;
   logic gnt_a, gnt_b, busy_a, busy_b, scl_a, scl_b, cs_a, cs_b, mosi_a, mosi_b;
   logic miso_a = 1'b0, miso_b = 1'b0;

   spi_master_arbiter #(.CLK_DIV(2)) dut_a (
      .clk(clk), .rst(rst), .req(req_a), .wdata0(w0_a), .wdata1(w1_a),
      .rdata(rdata_a), .done(done_a), .gnt_id(gnt_a), .busy(busy_a),
      .scl(scl_a), .cs(cs_a), .mosi(mosi_a), .miso(miso_a));

   spi_master_arbiter #(.CLK_DIV(1)) dut_b (
      .clk(clk), .rst(rst), .req(req_b), .wdata0(w0_b), .wdata1(w1_b),
      .rdata(rdata_b), .done(done_b), .gnt_id(gnt_b), .busy(busy_b),
      .scl(scl_b), .cs(cs_b), .mosi(mosi_b), .miso(miso_b));

   // Slave models: sample mosi and present the next miso bit on each scl rise
   logic [7:0] sd_a = '0, sd_b = '0, srx_a = '0, srx_b = '0;
   int scnt_a = 0, scnt_b = 0;
   always @(posedge scl_a or negedge rst) begin
      if (!rst) scnt_a = 0;
      else if (!cs_a) begin
         srx_a[scnt_a] = mosi_a;
         miso_a = sd_a[scnt_a];
         scnt_a = (scnt_a + 1) % 8;
      end
   end
   always @(posedge scl_b or negedge rst) begin
      if (!rst) scnt_b = 0;
      else if (!cs_b) begin
         srx_b[scnt_b] = mosi_b;
         miso_b = sd_b[scnt_b];
         scnt_b = (scnt_b + 1) % 8;
      end
   end

   int n_checks = 0, n_err = 0, cyc = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Frame model: everything derives from the grant edge E0 and the t = cycle-E0 timing rules
   bit       m_act [2];
   int       m_e0  [2];
   bit       m_gnt [2];
   bit       m_last[2] = '{1'b1, 1'b1};
   bit [7:0] m_tx  [2];
   bit [7:0] m_sd  [2];
   bit [7:0] m_rd  [2];

   task automatic model_check(input int i, input int cd, input logic rs, input logic [1:0] rq,
                              input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] sd,
                              input logic [7:0] srx, input logic [7:0] rd, input logic [1:0] dn,
                              input logic g, input logic b, input logic sc, input logic c,
                              input logic mo);
      string p = (i == 0) ? "a." : "b.";
      int t, bi;
      logic [1:0] e_dn = '0;
      logic e_cs = 1'b1, e_scl = 1'b0, e_busy = 1'b0;
      if (!rs) begin
         m_act[i] = 0; m_gnt[i] = 0; m_last[i] = 1; m_rd[i] = '0;
      end else begin
         t = cyc - m_e0[i];
         if (!m_act[i] || t == 18 * cd) begin
            if (rq != 2'b00) begin
               m_gnt[i] = (rq == 2'b11) ? ~m_last[i] : rq[1];
               m_tx[i]  = m_gnt[i] ? w1 : w0;
               m_sd[i]  = sd;
               m_e0[i]  = cyc;
               m_act[i] = 1;
            end else begin
               m_act[i] = 0;
            end
         end
         if (m_act[i]) begin
            t = cyc - m_e0[i];
            e_busy = 1'b1;
            e_cs   = (t >= 17 * cd);
            e_scl  = (t >= cd) && (t < 17 * cd) && (((t / cd) % 2) == 1);
            if (t == 17 * cd) begin
               e_dn = m_gnt[i] ? 2'b10 : 2'b01;
               m_last[i] = m_gnt[i];
               m_rd[i] = m_sd[i];
               chk({p, "slave_rx"}, srx, m_tx[i]);
            end
            if (!e_cs) begin
               bi = t / (2 * cd);
               if (bi > 7) bi = 7;
               chk({p, "mosi"}, mo, m_tx[i][bi]);
            end
         end
      end
      chk({p, "cs"}, c, e_cs);
      chk({p, "scl"}, sc, e_scl);
      chk({p, "busy"}, b, e_busy);
      chk({p, "done"}, dn, e_dn);
      chk({p, "gnt_id"}, g, m_gnt[i]);
      chk({p, "rdata"}, rd, m_rd[i]);
   endtask

   always @(posedge clk) begin
      logic [1:0] rqa, rqb;
      cyc++;
      rqa = req_a;
      rqb = req_b;
      #1;
      model_check(0, 2, rst, rqa, w0_a, w1_a, sd_a, srx_a, rdata_a, done_a, gnt_a, busy_a, scl_a, cs_a, mosi_a);
      model_check(1, 1, rst, rqb, w0_b, w1_b, sd_b, srx_b, rdata_b, done_b, gnt_b, busy_b, scl_b, cs_b, mosi_b);
   end

   // Waits for one frame to finish, measuring grant edge, scl rises/high cycles and done
   task automatic run_frame(input int i, output int e0, output int dc, output int rises,
                            output int highs, output logic [1:0] dn, output logic g);
      logic pcs, pscl, ccs, cscl;
      bit ok = 0;
      e0 = -1; dc = -1; rises = 0; highs = 0; dn = '0; g = 1'b0;
      pcs = (i == 0) ? cs_a : cs_b;
      pscl = (i == 0) ? scl_a : scl_b;
      for (int k = 0; k < 120; k++) begin
         @(posedge clk);
         #2;
         ccs  = (i == 0) ? cs_a : cs_b;
         cscl = (i == 0) ? scl_a : scl_b;
         if (pcs && !ccs) e0 = cyc;
         if (cscl && !pscl) rises++;
         if (cscl) highs++;
         pcs = ccs;
         pscl = cscl;
         dn = (i == 0) ? done_a : done_b;
         if (dn != 2'b00) begin
            dc = cyc;
            g = (i == 0) ? gnt_a : gnt_b;
            ok = 1;
            break;
         end
      end
      if (!ok) chk("frame_timeout", 0, 1);
   endtask

   initial begin
      int e0, dc, rises, highs, e0p;
      logic [1:0] dn;
      logic g;
      logic [1:0] dseq[4];
      logic gseq[4];

      repeat (3) @(negedge clk);
      chk("rst.cs", cs_a, 1); chk("rst.scl", scl_a, 0); chk("rst.mosi", mosi_a, 0);
      chk("rst.busy", busy_a, 0); chk("rst.done", done_a, 0); chk("rst.rdata", rdata_a, 0);
      chk("rst.gnt_id", gnt_a, 0);
      rst = 1'b1;

      // Single requester 0, slave returns 0x3C
      @(negedge clk);
      sd_a = 8'h3C; w0_a = 8'hA5; w1_a = 8'h00; req_a = 2'b01;
      run_frame(0, e0, dc, rises, highs, dn, g);
      chk("t1.latency", dc - e0, 34);
      chk("t1.rises", rises, 8);
      chk("t1.highs", highs, 16);
      chk("t1.rdata", rdata_a, 8'h3C);
      chk("t1.slave_rx", srx_a, 8'hA5);
      chk("t1.done", dn, 2'b01);
      @(negedge clk);
      req_a = 2'b00;
      repeat (3) @(negedge clk);

      // Tie straight after reset: requester 0 first, then 1, 36 cycles apart
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      w0_a = 8'h11; w1_a = 8'h22; sd_a = 8'h81; req_a = 2'b11;
      run_frame(0, e0, dc, rises, highs, dn, g);
      chk("t2.first_gnt", g, 0);
      chk("t2.first_done", dn, 2'b01);
      @(negedge clk);
      req_a = 2'b10;
      run_frame(0, e0p, dc, rises, highs, dn, g);
      chk("t2.second_gnt", g, 1);
      chk("t2.second_done", dn, 2'b10);
      chk("t2.period", e0p - e0, 36);
      chk("t2.slave_rx", srx_a, 8'h22);
      @(negedge clk);
      req_a = 2'b00;
      repeat (4) @(negedge clk);

      // Four frames with both requesting continuously
      req_a = 2'b11;
      for (int f = 0; f < 4; f++) begin
         run_frame(0, e0, dc, rises, highs, dn, g);
         gseq[f] = g;
         dseq[f] = dn;
      end
      chk("t3.g0", gseq[0], 0); chk("t3.g1", gseq[1], 1);
      chk("t3.g2", gseq[2], 0); chk("t3.g3", gseq[3], 1);
      chk("t3.d0", dseq[0], 2'b01); chk("t3.d1", dseq[1], 2'b10);
      chk("t3.d2", dseq[2], 2'b01); chk("t3.d3", dseq[3], 2'b10);
      @(negedge clk);
      req_a = 2'b00;
      repeat (4) @(negedge clk);

      // wdata0 changed two cycles after grant must not reach the slave
      w0_a = 8'hA5; req_a = 2'b01;
      @(posedge clk);
      #2;
      chk("t4.cs_at_grant", cs_a, 0);
      @(negedge clk);
      @(negedge clk);
      w0_a = 8'hFF;
      run_frame(0, e0, dc, rises, highs, dn, g);
      chk("t4.slave_rx", srx_a, 8'hA5);
      @(negedge clk);
      req_a = 2'b00;
      w0_a = 8'hA5;
      repeat (3) @(negedge clk);

      // Reset after the third scl rise aborts the frame
      w0_a = 8'h77; req_a = 2'b01;
      rises = 0;
      begin
         logic pscl = 1'b0;
         for (int k = 0; k < 60 && rises < 3; k++) begin
            @(posedge clk);
            #2;
            if (scl_a && !pscl) rises++;
            pscl = scl_a;
         end
      end
      chk("t5.reached_rise3", rises, 3);
      @(negedge clk);
      rst = 1'b0;
      req_a = 2'b00;
      #1;
      chk("t5.cs", cs_a, 1); chk("t5.scl", scl_a, 0);
      chk("t5.busy", busy_a, 0); chk("t5.done", done_a, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      w0_a = 8'h5A; sd_a = 8'hC3; req_a = 2'b01;
      run_frame(0, e0, dc, rises, highs, dn, g);
      chk("t5.slave_rx", srx_a, 8'h5A);
      chk("t5.rdata", rdata_a, 8'hC3);
      chk("t5.done", dn, 2'b01);
      chk("t5.rises", rises, 8);
      @(negedge clk);
      req_a = 2'b00;
      repeat (3) @(negedge clk);

      // CLK_DIV = 1 instance
      w0_b = 8'h96; sd_b = 8'h69; req_b = 2'b01;
      run_frame(1, e0, dc, rises, highs, dn, g);
      chk("t6.latency", dc - e0, 17);
      chk("t6.rises", rises, 8);
      chk("t6.highs", highs, 8);
      chk("t6.rdata", rdata_b, 8'h69);
      chk("t6.slave_rx", srx_b, 8'h96);
      @(negedge clk);
      req_b = 2'b00;
      repeat (4) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
